// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between an ALU (A) and a load (B) writeback
// queue and flags RAW hazards. Define RF_ARB_RR_EN for round-robin; default is A-priority.
module regfile_wr_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        reg_write,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        busy
);

  // Handshake: a beat moves on a posedge with valid && ready. Ready depends only
  // on queue occupancy, so a requester may hold valid and wait for ready.
  logic [4:0]       qa_addr [DEPTH];
  logic [31:0]      qa_data [DEPTH];
  logic [DEPTH-1:0] qa_vld;
  logic             qa_wptr, qa_rptr;

  logic [4:0]       qb_addr [DEPTH];
  logic [31:0]      qb_data [DEPTH];
  logic [DEPTH-1:0] qb_vld;
  logic             qb_wptr, qb_rptr;

  logic        a_push, b_push;
  logic        a_ne, b_ne;
  logic        a_wins;
  logic        grant_a, grant_b;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign a_ready = ~(&qa_vld) && rst_n;
  assign b_ready = ~(&qb_vld) && rst_n;
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign a_ne    = |qa_vld;
  assign b_ne    = |qb_vld;

`ifdef RF_ARB_RR_EN
  // Set when B held the most recent grant; reset to B so A wins the first contest.
  logic last_b;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end

  assign a_wins = last_b;
`else
  assign a_wins = 1'b1;
`endif

  assign grant_a = a_ne && (!b_ne || a_wins);
  assign grant_b = b_ne && !grant_a;

  // Queue A control: with one entry held, wptr and rptr differ, so a
  // simultaneous push and pop never touch the same slot.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      qa_vld  <= '0;
      qa_wptr <= 1'b0;
      qa_rptr <= 1'b0;
    end else begin
      if (a_push) begin
        qa_vld[qa_wptr] <= 1'b1;
        qa_wptr         <= ~qa_wptr;
      end
      if (grant_a) begin
        qa_vld[qa_rptr] <= 1'b0;
        qa_rptr         <= ~qa_rptr;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (a_push) begin
      qa_addr[qa_wptr] <= a_addr;
      qa_data[qa_wptr] <= a_data;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      qb_vld  <= '0;
      qb_wptr <= 1'b0;
      qb_rptr <= 1'b0;
    end else begin
      if (b_push) begin
        qb_vld[qb_wptr] <= 1'b1;
        qb_wptr         <= ~qb_wptr;
      end
      if (grant_b) begin
        qb_vld[qb_rptr] <= 1'b0;
        qb_rptr         <= ~qb_rptr;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (b_push) begin
      qb_addr[qb_wptr] <= b_addr;
      qb_data[qb_wptr] <= b_data;
    end
  end

  always_comb begin
    head_addr = qb_addr[qb_rptr];
    head_data = qb_data[qb_rptr];
    if (grant_a) begin
      head_addr = qa_addr[qa_rptr];
      head_data = qa_data[qa_rptr];
    end
  end

  // Register-0 writes still load the port registers but never strobe.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (grant_a || grant_b) begin
      reg_write <= (head_addr != 5'd0);
      wr_addr   <= head_addr;
      wr_data   <= head_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    if (qa_vld[0] && (qa_addr[0] == rd_addr1)) hazard1 = 1'b1;
    if (qa_vld[1] && (qa_addr[1] == rd_addr1)) hazard1 = 1'b1;
    if (qb_vld[0] && (qb_addr[0] == rd_addr1)) hazard1 = 1'b1;
    if (qb_vld[1] && (qb_addr[1] == rd_addr1)) hazard1 = 1'b1;
    if (reg_write && (wr_addr == rd_addr1))    hazard1 = 1'b1;
    if (qa_vld[0] && (qa_addr[0] == rd_addr2)) hazard2 = 1'b1;
    if (qa_vld[1] && (qa_addr[1] == rd_addr2)) hazard2 = 1'b1;
    if (qb_vld[0] && (qb_addr[0] == rd_addr2)) hazard2 = 1'b1;
    if (qb_vld[1] && (qb_addr[1] == rd_addr2)) hazard2 = 1'b1;
    if (reg_write && (wr_addr == rd_addr2))    hazard2 = 1'b1;
    if (rd_addr1 == 5'd0) hazard1 = 1'b0;
    if (rd_addr2 == 5'd0) hazard2 = 1'b0;
  end

  assign busy = a_ne || b_ne || reg_write;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic, all
// compared against a queue-based model of the two writeback streams.
module tb_regfile_wr_arbiter;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        hazard1, hazard2, busy;

  always #5 clka = ~clka;

  regfile_wr_arbiter dut (
    .clka(clka), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: entries are {addr, data}; exp_q* are the pending writes per requester.
  logic [36:0] exp_qa[$];
  logic [36:0] exp_qb[$];
  logic [36:0] a_src[$];
  logic [36:0] b_src[$];
  logic [4:0]  ret_log[$];
  logic        m_last_b, m_rw;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          a_en = 1'b1;
  bit          b_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_haz(input logic [4:0] ra);
    logic h;
    h = 1'b0;
    foreach (exp_qa[i]) if (exp_qa[i][36:32] == ra) h = 1'b1;
    foreach (exp_qb[i]) if (exp_qb[i][36:32] == ra) h = 1'b1;
    if (m_rw && (m_waddr == ra)) h = 1'b1;
    return (ra != 5'd0) && h;
  endfunction

  task automatic model_reset();
    exp_qa.delete();
    exp_qb.delete();
    m_rw     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_last_b = 1'b1;
  endtask

  task automatic check_all();
    chk("reg_write", reg_write, m_rw);
    chk("wr_addr", wr_addr, m_waddr);
    chk("wr_data", wr_data, m_wdata);
    chk("a_ready", a_ready, rst_n && (exp_qa.size() < 2));
    chk("b_ready", b_ready, rst_n && (exp_qb.size() < 2));
    chk("busy", busy, (exp_qa.size() > 0) || (exp_qb.size() > 0) || m_rw);
    chk("hazard1", hazard1, m_haz(rd_addr1));
    chk("hazard2", hazard2, m_haz(rd_addr2));
  endtask

  task automatic drive();
    a_valid = a_en && (a_src.size() > 0);
    b_valid = b_en && (b_src.size() > 0);
    if (a_src.size() > 0) begin
      a_addr = a_src[0][36:32];
      a_data = a_src[0][31:0];
    end
    if (b_src.size() > 0) begin
      b_addr = b_src[0][36:32];
      b_data = b_src[0][31:0];
    end
  endtask

  // One clock: decide model transition from pre-edge inputs, then check at negedge.
  task automatic tick();
    logic pa, pb, ga, gb, a_pri;
    logic [36:0] e;
    pa = a_valid && rst_n && (exp_qa.size() < 2);
    pb = b_valid && rst_n && (exp_qb.size() < 2);
`ifdef RF_ARB_RR_EN
    a_pri = m_last_b;
`else
    a_pri = 1'b1;
`endif
    ga = rst_n && (exp_qa.size() > 0) && ((exp_qb.size() == 0) || a_pri);
    gb = rst_n && !ga && (exp_qb.size() > 0);
    @(posedge clka);
    if (ga) begin
      e = exp_qa.pop_front();
      m_rw = (e[36:32] != 5'd0); m_waddr = e[36:32]; m_wdata = e[31:0]; m_last_b = 1'b0;
    end else if (gb) begin
      e = exp_qb.pop_front();
      m_rw = (e[36:32] != 5'd0); m_waddr = e[36:32]; m_wdata = e[31:0]; m_last_b = 1'b1;
    end else begin
      m_rw = 1'b0;
    end
    if (pa) exp_qa.push_back(a_src.pop_front());
    if (pb) exp_qb.push_back(b_src.pop_front());
    @(negedge clka);
    check_all();
    if (reg_write === 1'b1) ret_log.push_back(wr_addr);
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    logic [4:0] exp_order[4];
    model_reset();
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd9;
    repeat (2) @(negedge clka);
    check_all();
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Single write through A
    a_src.push_back({5'd3, 32'h0000_00AA});
    drive();
    tick();
    chk("single_accept_rw", reg_write, 1'b0);
    tick();
    chk("single_rw", reg_write, 1'b1);
    chk("single_addr", wr_addr, 5'd3);
    chk("single_data", wr_data, 32'h0000_00AA);
    tick();
    chk("single_rw_drop", reg_write, 1'b0);
    chk("single_busy", busy, 1'b0);

    // Register 0 discard through B
    rd_addr1 = 5'd0;
    b_src.push_back({5'd0, 32'hDEAD_BEEF});
    drive();
    repeat (4) begin
      tick();
      chk("r0_no_write", reg_write, 1'b0);
      chk("r0_hazard1", hazard1, 1'b0);
    end

    // Contention between A and B
    ret_log.delete();
    for (int i = 0; i < 4; i++) begin
      a_src.push_back({5'(i + 1), $urandom});
      b_src.push_back({5'(i + 17), $urandom});
    end
    drive();
    repeat (12) tick();
`ifdef RF_ARB_RR_EN
    exp_order = '{5'd1, 5'd17, 5'd2, 5'd18};
`else
    exp_order = '{5'd1, 5'd2, 5'd3, 5'd4};
`endif
    chk("contend_count", ret_log.size(), 8);
    if (ret_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("contend_order", ret_log[i], exp_order[i]);

    // Backpressure on B
    for (int i = 0; i < 4; i++) begin
      a_src.push_back({5'(i + 9), $urandom});
      b_src.push_back({5'(i + 24), $urandom});
    end
    drive();
    tick();
    tick();
    chk("bp_b_ready", b_ready, 1'b0);
    repeat (12) tick();
    chk("bp_drained", busy, 1'b0);

    // Hazard tracking on rd_addr2
    rd_addr1 = 5'd8;
    rd_addr2 = 5'd7;
    a_src.push_back({5'd7, 32'h0000_0077});
    drive();
    tick();
    chk("haz_queued", hazard2, 1'b1);
    chk("haz_other", hazard1, 1'b0);
    tick();
    chk("haz_inflight", hazard2, 1'b1);
    tick();
    chk("haz_cleared", hazard2, 1'b0);
    rd_addr2 = 5'd8;
    #1;
    chk("haz_nomatch", hazard2, 1'b0);

    // Mid-operation reset
    for (int i = 0; i < 4; i++) begin
      a_src.push_back({5'(i + 1), $urandom});
      b_src.push_back({5'(i + 20), $urandom});
    end
    drive();
    repeat (3) tick();
    chk("pre_reset_rw", reg_write, 1'b1);
    #2;
    rst_n = 1'b0;
    a_src.delete();
    b_src.delete();
    model_reset();
    drive();
    #1;
    check_all();
    chk("midrst_rw", reg_write, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_rw", reg_write, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      a_src.push_back({5'($urandom_range(0, 7)), $urandom});
      b_src.push_back({5'($urandom_range(0, 7)), $urandom});
    end
    cycles = 0;
    while (((a_src.size() + b_src.size() + exp_qa.size() + exp_qb.size()) > 0) && (cycles < 3000)) begin
      a_en     = 1'($urandom_range(0, 1));
      b_en     = 1'($urandom_range(0, 1));
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 7));
      drive();
      tick();
      cycles++;
    end
    chk("random_drained", a_src.size() + b_src.size() + exp_qa.size() + exp_qb.size(), 0);
    a_en = 1'b1;
    b_en = 1'b1;
    tick();
    chk("final_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
